// File: rtl/alu_sequencer_if.sv
// Bundle of the sequencer's fetch, register-file, ALU-control and data-memory signals.
// master = sequencer side, slave = environment (memories, register file, ALU).
interface alu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic            instr_req;
  logic [PC_W-1:0] instr_addr;
  logic            instr_ack;
  logic [15:0]     instr_data;
  logic [2:0]      rf_ra;
  logic [2:0]      rf_rb;
  logic [2:0]      rf_wa;
  logic            rf_we;
  logic [1:0]      alu_cond;
  logic [3:0]      alu_op;
  logic [6:0]      alu_ldsh;
  logic [3:0]      alu_flags;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack;
  logic [3:0]      flags;
  logic            busy;
  logic            halted;

  modport master (
    input  run, instr_ack, instr_data, alu_flags, mem_ack,
    output instr_req, instr_addr, rf_ra, rf_rb, rf_wa, rf_we,
           alu_cond, alu_op, alu_ldsh, mem_req, mem_we, flags, busy, halted
  );

  modport slave (
    output run, instr_ack, instr_data, alu_flags, mem_ack,
    input  instr_req, instr_addr, rf_ra, rf_rb, rf_wa, rf_we,
           alu_cond, alu_op, alu_ldsh, mem_req, mem_we, flags, busy, halted
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit words, gates them on the
// {N,Z,C,V} condition, and steps the external ALU, data memory and register file.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instr_req held until instr_ack, IR captured on ack
// DECODE | register read addresses out, halt/condition decision
// EXEC   | ALU control driven, flags captured for ADD/SUB/MUL/CMP
// MEM    | mem_req held until mem_ack (LDR/STR)
// WB     | single-cycle register write-back
// HALT   | terminal until reset
module alu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;
  localparam logic [15:0] IR_HALT = 16'hFFFF;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [3:0]      flags_q;

  logic            pc_inc;
  logic            ir_load;
  logic            flags_load;
  logic            cond_ok;
  logic [3:0]      op;

  logic            instr_req;
  logic            mem_req;
  logic            mem_we;
  logic            rf_we;
  logic [2:0]      rf_wa;
  logic [2:0]      rf_ra;
  logic [2:0]      rf_rb;
  logic [3:0]      alu_op;
  logic [1:0]      alu_cond;
  logic [6:0]      alu_ldsh;

  assign op = ir[13:10];

  // flags_q is {N,Z,C,V}
  always_comb begin
    cond_ok = 1'b0;
    unique case (ir[15:14])
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = flags_q[2];
      2'b10: cond_ok = ~flags_q[2];
      2'b11: cond_ok = flags_q[3] ^ flags_q[0];
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    flags_load = 1'b0;
    instr_req  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = 3'd0;
    rf_ra      = 3'd0;
    rf_rb      = 3'd0;
    alu_op     = OP_NOP;
    alu_cond   = 2'b00;
    alu_ldsh   = 7'd0;

    unique case (state)
      IDLE: begin
        if (bus.run) state_nxt = FETCH;
      end

      FETCH: begin
        instr_req = 1'b1;
        if (bus.instr_ack) begin
          ir_load   = 1'b1;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        rf_ra = ir[9:7];
        rf_rb = ir[6:4];
        if (ir == IR_HALT) begin
          state_nxt = HALT;
        end else if (cond_ok) begin
          state_nxt = EXEC;
        end else begin
          pc_inc    = 1'b1;
          state_nxt = FETCH;
        end
      end

      EXEC: begin
        rf_ra    = ir[9:7];
        rf_rb    = ir[6:4];
        alu_op   = op;
        alu_cond = ir[15:14];
        alu_ldsh = ir[6:0];
        flags_load = (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_MUL) || (op == OP_CMP);
        if ((op == OP_LDR) || (op == OP_STR)) begin
          state_nxt = MEM;
        end else if ((op == OP_CMP) || (op == OP_NOP)) begin
          pc_inc    = 1'b1;
          state_nxt = FETCH;
        end else begin
          state_nxt = WB;
        end
      end

      MEM: begin
        rf_ra   = ir[9:7];
        rf_rb   = ir[6:4];
        mem_req = 1'b1;
        mem_we  = (op == OP_STR);
        if (bus.mem_ack) begin
          if (op == OP_STR) begin
            pc_inc    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end

      WB: begin
        rf_ra     = ir[9:7];
        rf_rb     = ir[6:4];
        alu_op    = op;
        alu_cond  = ir[15:14];
        alu_ldsh  = ir[6:0];
        rf_we     = 1'b1;
        rf_wa     = ir[9:7];
        pc_inc    = 1'b1;
        state_nxt = FETCH;
      end

      HALT: begin
        state_nxt = HALT;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PC wraps naturally at PC_W bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= 16'h0000;
      flags_q <= 4'h0;
    end else begin
      if (pc_inc)     pc      <= pc + 1'b1;
      if (ir_load)    ir      <= bus.instr_data;
      if (flags_load) flags_q <= bus.alu_flags;
    end
  end

  assign bus.instr_req  = instr_req;
  assign bus.instr_addr = pc;
  assign bus.rf_ra      = rf_ra;
  assign bus.rf_rb      = rf_rb;
  assign bus.rf_wa      = rf_wa;
  assign bus.rf_we      = rf_we;
  assign bus.alu_cond   = alu_cond;
  assign bus.alu_op     = alu_op;
  assign bus.alu_ldsh   = alu_ldsh;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.flags      = flags_q;
  assign bus.busy       = (state != IDLE) && (state != HALT);
  assign bus.halted     = (state == HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: drives fetch/memory handshakes by hand and
// checks outputs on the falling edge against hand-computed values.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  int   excl_bad;

  alu_sequencer_if #(.PC_W(8)) bus ();

  alu_sequencer #(.PC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ((int'(bus.rf_we) + int'(bus.instr_req) + int'(bus.mem_req)) > 1))
      excl_bad++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.instr_ack = 1'b0; bus.mem_ack = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic start();
    bus.run = 1'b1;
    step(1);
    bus.run = 1'b0;
  endtask

  // Called on a falling edge while in FETCH; returns on the falling edge in DECODE.
  task automatic feed(input logic [15:0] w);
    bus.instr_data = w;
    bus.instr_ack  = 1'b1;
    step(1);
    bus.instr_ack  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.instr_req !== 1'b0) $display("FAIL rst_instr_req: got %b want 0", bus.instr_req); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", bus.halted); else passed++;
    checks++; if (bus.alu_op !== 4'hF) $display("FAIL rst_alu_op: got %h want f", bus.alu_op); else passed++;
    checks++; if (bus.flags !== 4'h0) $display("FAIL rst_flags: got %h want 0", bus.flags); else passed++;
    checks++; if (bus.instr_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", bus.instr_addr); else passed++;
    checks++; if ({bus.mem_req, bus.rf_we, bus.alu_ldsh, bus.alu_cond} !== 11'd0) $display("FAIL rst_outs: got %h want 0", {bus.mem_req, bus.rf_we, bus.alu_ldsh, bus.alu_cond}); else passed++;
    step(3);
    checks++; if (bus.instr_req !== 1'b0) $display("FAIL rst_no_run: got %b want 0", bus.instr_req); else passed++;
  endtask

  task automatic test_add();
    do_reset();
    bus.alu_flags = 4'b1001;
    start();
    checks++; if (bus.instr_req !== 1'b1) $display("FAIL add_fetch_req: got %b want 1", bus.instr_req); else passed++;
    checks++; if (bus.instr_addr !== 8'h00) $display("FAIL add_fetch_addr: got %h want 00", bus.instr_addr); else passed++;
    feed(16'h00A0);
    checks++; if ({bus.rf_ra, bus.rf_rb} !== {3'd1, 3'd2}) $display("FAIL add_dec_ra_rb: got %h want %h", {bus.rf_ra, bus.rf_rb}, {3'd1, 3'd2}); else passed++;
    checks++; if (bus.instr_req !== 1'b0) $display("FAIL add_dec_req: got %b want 0", bus.instr_req); else passed++;
    step(1);
    checks++; if (bus.alu_op !== 4'h0) $display("FAIL add_exec_op: got %h want 0", bus.alu_op); else passed++;
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL add_exec_we: got %b want 0", bus.rf_we); else passed++;
    step(1);
    checks++; if ({bus.rf_we, bus.rf_wa} !== {1'b1, 3'd1}) $display("FAIL add_wb: got we/wa %h want %h", {bus.rf_we, bus.rf_wa}, {1'b1, 3'd1}); else passed++;
    checks++; if (bus.flags !== 4'b1001) $display("FAIL add_flags: got %b want 1001", bus.flags); else passed++;
    step(1);
    checks++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'h01}) $display("FAIL add_next_fetch: got %h want %h", {bus.instr_req, bus.instr_addr}, {1'b1, 8'h01}); else passed++;
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL add_we_drop: got %b want 0", bus.rf_we); else passed++;
  endtask

  task automatic test_cond();
    do_reset();
    bus.alu_flags = 4'b0100;
    start();
    feed(16'h2CA0);
    step(1);
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL cmp_no_we: got %b want 0", bus.rf_we); else passed++;
    step(1);
    checks++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'h01}) $display("FAIL cmp_latency: got %h want %h", {bus.instr_req, bus.instr_addr}, {1'b1, 8'h01}); else passed++;
    checks++; if (bus.flags !== 4'b0100) $display("FAIL cmp_flags: got %b want 0100", bus.flags); else passed++;
    feed(16'h41C0);
    step(2);
    checks++; if ({bus.rf_we, bus.rf_wa} !== {1'b1, 3'd3}) $display("FAIL condeq_wb: got %h want %h", {bus.rf_we, bus.rf_wa}, {1'b1, 3'd3}); else passed++;
    step(1);
    checks++; if (bus.instr_addr !== 8'h02) $display("FAIL condeq_pc: got %h want 02", bus.instr_addr); else passed++;
    bus.alu_flags = 4'b1111;
    feed(16'h82E0);
    checks++; if ({bus.rf_we, bus.alu_op, bus.mem_req} !== {1'b0, 4'hF, 1'b0}) $display("FAIL condne_dec: got %h want %h", {bus.rf_we, bus.alu_op, bus.mem_req}, {1'b0, 4'hF, 1'b0}); else passed++;
    step(1);
    checks++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'h03}) $display("FAIL condne_skip: got %h want %h", {bus.instr_req, bus.instr_addr}, {1'b1, 8'h03}); else passed++;
    checks++; if (bus.flags !== 4'b0100) $display("FAIL condne_flags: got %b want 0100", bus.flags); else passed++;
    feed(16'hC2E0);
    step(1);
    checks++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'h04}) $display("FAIL condnv_skip: got %h want %h", {bus.instr_req, bus.instr_addr}, {1'b1, 8'h04}); else passed++;
  endtask

  task automatic test_mem();
    do_reset();
    bus.alu_flags = 4'b1111;
    start();
    bus.mem_ack = 1'b1;
    step(1);
    bus.mem_ack = 1'b0;
    checks++; if ({bus.instr_req, bus.mem_req, bus.instr_addr} !== {1'b1, 1'b0, 8'h00}) $display("FAIL stray_mem_ack: got %h want %h", {bus.instr_req, bus.mem_req, bus.instr_addr}, {1'b1, 1'b0, 8'h00}); else passed++;
    feed(16'h3680);
    step(2);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus.mem_req, bus.mem_we, bus.rf_we} !== 3'b100) $display("FAIL ldr_mem_cyc%0d: got req/we/rfwe %b want 100", i, {bus.mem_req, bus.mem_we, bus.rf_we}); else passed++;
      checks++; if (bus.alu_op !== 4'hF) $display("FAIL ldr_mem_op%0d: got %h want f", i, bus.alu_op); else passed++;
      if (i == 3) bus.mem_ack = 1'b1;
      step(1);
    end
    bus.mem_ack = 1'b0;
    checks++; if ({bus.rf_we, bus.rf_wa, bus.mem_req} !== {1'b1, 3'd5, 1'b0}) $display("FAIL ldr_wb: got %h want %h", {bus.rf_we, bus.rf_wa, bus.mem_req}, {1'b1, 3'd5, 1'b0}); else passed++;
    step(1);
    checks++; if ({bus.rf_we, bus.instr_addr} !== {1'b0, 8'h01}) $display("FAIL ldr_next: got %h want %h", {bus.rf_we, bus.instr_addr}, {1'b0, 8'h01}); else passed++;
    checks++; if (bus.flags !== 4'h0) $display("FAIL ldr_flags: got %h want 0", bus.flags); else passed++;
    feed(16'h3B00);
    step(2);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus.mem_req, bus.mem_we, bus.rf_we} !== 3'b110) $display("FAIL str_mem_cyc%0d: got req/we/rfwe %b want 110", i, {bus.mem_req, bus.mem_we, bus.rf_we}); else passed++;
      if (i == 3) bus.mem_ack = 1'b1;
      step(1);
    end
    bus.mem_ack = 1'b0;
    checks++; if ({bus.rf_we, bus.mem_req, bus.instr_req, bus.instr_addr} !== {1'b0, 1'b0, 1'b1, 8'h02}) $display("FAIL str_next: got %h want %h", {bus.rf_we, bus.mem_req, bus.instr_req, bus.instr_addr}, {1'b0, 1'b0, 1'b1, 8'h02}); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    start();
    for (int i = 0; i < 255; i++) begin
      feed(16'h3C00);
      step(2);
    end
    checks++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'hFF}) $display("FAIL wrap_pre: got %h want %h", {bus.instr_req, bus.instr_addr}, {1'b1, 8'hFF}); else passed++;
    feed(16'h3C00);
    step(2);
    checks++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'h00}) $display("FAIL wrap_post: got %h want %h", {bus.instr_req, bus.instr_addr}, {1'b1, 8'h00}); else passed++;
  endtask

  task automatic test_halt();
    feed(16'hFFFF);
    checks++; if (bus.busy !== 1'b1) $display("FAIL halt_dec_busy: got %b want 1", bus.busy); else passed++;
    step(1);
    checks++; if ({bus.halted, bus.busy, bus.instr_req} !== 3'b100) $display("FAIL halt_state: got %b want 100", {bus.halted, bus.busy, bus.instr_req}); else passed++;
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if ({bus.halted, bus.instr_req} !== 2'b10) $display("FAIL halt_run%0d: got %b want 10", i, {bus.halted, bus.instr_req}); else passed++;
    end
    bus.run = 1'b0;
    do_reset();
    checks++; if ({bus.halted, bus.busy} !== 2'b00) $display("FAIL halt_reset: got %b want 00", {bus.halted, bus.busy}); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.alu_flags = 4'b1010;
    start();
    feed(16'h2CA0);
    step(2);
    checks++; if (bus.flags !== 4'b1010) $display("FAIL mid_pre_flags: got %b want 1010", bus.flags); else passed++;
    feed(16'h3680);
    step(2);
    checks++; if (bus.mem_req !== 1'b1) $display("FAIL mid_mem_req: got %b want 1", bus.mem_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_req, bus.rf_we, bus.busy, bus.halted} !== 4'b0000) $display("FAIL mid_mem_drop: got %b want 0000", {bus.mem_req, bus.rf_we, bus.busy, bus.halted}); else passed++;
    checks++; if ({bus.flags, bus.instr_addr} !== 12'h000) $display("FAIL mid_mem_state: got %h want 000", {bus.flags, bus.instr_addr}); else passed++;
    step(1);
    rst_n = 1'b1;
    step(3);
    checks++; if ({bus.instr_req, bus.busy} !== 2'b00) $display("FAIL mid_no_restart: got %b want 00", {bus.instr_req, bus.busy}); else passed++;
    start();
    checks++; if (bus.instr_req !== 1'b1) $display("FAIL mid_fetch_req: got %b want 1", bus.instr_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.instr_req !== 1'b0) $display("FAIL mid_fetch_drop: got %b want 0", bus.instr_req); else passed++;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    checks = 0; passed = 0; excl_bad = 0;
    rst_n = 1'b0;
    bus.run = 1'b0; bus.instr_ack = 1'b0; bus.instr_data = 16'h0000;
    bus.alu_flags = 4'h0; bus.mem_ack = 1'b0;
    test_reset();
    test_add();
    test_cond();
    test_mem();
    test_wrap();
    test_halt();
    test_reset_mid();
    checks++; if (excl_bad !== 0) $display("FAIL req_exclusive: got %0d overlapping cycles want 0", excl_bad); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
